// File: rtl/mdr_load_unit_if.sv
// mdr_load_unit_if: data-memory read bus between the load unit and memory
// mem_addr: word-aligned read address, driven by the load unit
// mem_rd: read request, held until acknowledged or aborted
// mem_ack: memory response valid, driven by memory
// mem_rdata: little-endian read data, valid with mem_ack
interface mdr_load_unit_if;
  logic [31:0] mem_addr;
  logic mem_rd;
  logic mem_ack;
  logic [31:0] mem_rdata;
  modport master (output mem_addr, mem_rd, input mem_ack, mem_rdata);
  modport slave (input mem_addr, mem_rd, output mem_ack, mem_rdata);
endinterface

// File: rtl/mdr_load_unit.sv
// mdr_load_unit: issues data-memory reads and latches the extended byte/half/word into the MDR
// clk, reset_n: clock and asynchronous active-low reset
// start, addr, size, sign_ext: load request from the controller, sampled in IDLE
// mem: read bus to data memory (master side)
// MDRtoMux2: memory data register feeding the write-back select
// busy, done, err: status; done and err are one-cycle pulses
module mdr_load_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic [31:0] addr,
  input  logic [1:0] size,
  input  logic sign_ext,
  mdr_load_unit_if.master mem,
  output logic [31:0] MDRtoMux2,
  output logic busy,
  output logic done,
  output logic err
);
  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;
  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);
  state_t state, nxt;
  logic [7:0] cnt;
  logic [1:0] lane, sz;
  logic sx, legal;
  logic [7:0] b;
  logic [15:0] h;
  logic [31:0] ext;
  assign legal = !(size == 2'b11 || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00));
  assign b = mem.mem_rdata[{lane, 3'b000} +: 8];
  assign h = lane[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
  assign ext = sz == 2'b00 ? {{24{sx & b[7]}}, b} : sz == 2'b01 ? {{16{sx & h[15]}}, h} : mem.mem_rdata;
  // Ack is checked before the counter so an ack on the last allowed cycle still completes.
  always_comb begin
    nxt = IDLE;
    if (state == IDLE) nxt = start ? (legal ? REQ : ERR) : IDLE;
    else if (state == REQ) nxt = mem.mem_ack ? DONE : cnt == LAST ? ERR : REQ;
  end
  // Outputs decode straight from state so reset drops mem_rd immediately.
  assign mem.mem_rd = state == REQ;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign err = state == ERR;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      lane <= '0;
      sz <= '0;
      sx <= 1'b0;
      mem.mem_addr <= '0;
      MDRtoMux2 <= '0;
    end else begin
      state <= nxt;
      cnt <= state == REQ ? cnt + 8'd1 : 8'd0;
      if (state == IDLE && start && legal) begin
        mem.mem_addr <= {addr[31:2], 2'b00};
        lane <= addr[1:0];
        sz <= size;
        sx <= sign_ext;
      end
      if (state == REQ && mem.mem_ack) MDRtoMux2 <= ext;
    end
endmodule
